// File: rtl/v_hier_qcapture.sv
// v_hier_qcapture: watches the 4-bit qvec bus and records every change with
// a free-running cycle timestamp. Changes are queued in a small
// first-word-fall-through FIFO, drained via out_valid/out_ready. A sticky
// overflow flag remembers any change dropped because the FIFO was full.
module v_hier_qcapture #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               qvec,
  input  logic                     enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + TS_W;

  logic [3:0]      prev_q_reg;
  logic [TS_W-1:0] ts_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            overflow_reg;

  // Storage is deliberately left out of reset; occupancy is tracked by count.
  logic [EW-1:0]   mem [DEPTH];

  logic change;
  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign change   = (qvec != prev_q_reg);
  assign push_req = change && enable;
  assign full     = (count_reg == CW'(DEPTH));
  assign pop      = out_valid && out_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO is accepted.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign out_valid = (count_reg != '0);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign out_data  = out_valid ? mem[rd_ptr_reg][EW-1:TS_W] : 4'h0;
  assign out_ts    = out_valid ? mem[rd_ptr_reg][TS_W-1:0] : '0;

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Previous-value register and timestamp counter run regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q_reg <= 4'h0;
      ts_reg     <= '0;
    end else begin
      prev_q_reg <= qvec;
      ts_reg     <= ts_reg + TS_W'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Entry write: qvec with the timestamp value before this edge's increment.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {qvec, ts_reg};
  end

  // Sticky overflow; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (clr_ovf) overflow_reg <= 1'b0;
  end

endmodule
